// File: rtl/instr_byte_sender.sv
// instr_byte_sender: serialises a 16-bit instruction word (4-bit opcode plus
// 12-bit operand) into two bytes for a DIP-switch/push-button loader. Each
// byte has a setup phase, a button-high pulse and a button-low gap.
module instr_byte_sender #(
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned PULSE_CYC = 4,
  parameter int unsigned GAP_CYC   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [3:0]  in_opcode,
  input  logic [11:0] in_instr,
  output logic        in_ready,
  input  logic        abort,
  output logic [7:0]  data_out,
  output logic        btn_out,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SETUP0 = 3'd1;
  localparam logic [2:0] PULSE0 = 3'd2;
  localparam logic [2:0] GAP0   = 3'd3;
  localparam logic [2:0] SETUP1 = 3'd4;
  localparam logic [2:0] PULSE1 = 3'd5;
  localparam logic [2:0] GAP1   = 3'd6;

  // Counter reload values: a state lasting N cycles counts N-1 down to 0.
  localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC - 1);
  localparam logic [7:0] PULSE_LD = 8'(PULSE_CYC - 1);
  localparam logic [7:0] GAP_LD   = 8'(GAP_CYC - 1);

  logic [2:0]  state;
  logic [7:0]  cnt;
  logic [3:0]  op_q;
  logic [11:0] instr_q;
  logic        byte_sel;  // 0: byte0 on the bus, 1: byte1 on the bus

  // Presented byte is selected from the captured word, so it holds through
  // abort and IDLE and reads 8'h00 out of reset.
  always_comb begin
    data_out = byte_sel ? instr_q[11:4] : {instr_q[3:0], op_q};
  end

  // Status outputs decoded directly from the state register.
  always_comb begin
    in_ready = (state == IDLE);
    busy     = (state != IDLE);
    btn_out  = (state == PULSE0) || (state == PULSE1);
  end

  // Sequencer: capture, timed phase walk, abort handling and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      op_q     <= '0;
      instr_q  <= '0;
      byte_sel <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (in_valid) begin
          op_q     <= in_opcode;
          instr_q  <= in_instr;
          byte_sel <= 1'b0;
          state    <= SETUP0;
          cnt      <= SETUP_LD;
        end
      end else if (abort) begin
        state <= IDLE;
        cnt   <= '0;
      end else if (cnt != '0) begin
        cnt <= cnt - 8'd1;
      end else begin
        case (state)
          SETUP0: begin state <= PULSE0; cnt <= PULSE_LD; end
          PULSE0: begin state <= GAP0;   cnt <= GAP_LD;   end
          GAP0: begin
            state    <= SETUP1;
            cnt      <= SETUP_LD;
            byte_sel <= 1'b1;
          end
          SETUP1: begin state <= PULSE1; cnt <= PULSE_LD; end
          PULSE1: begin state <= GAP1;   cnt <= GAP_LD;   end
          GAP1: begin
            state <= IDLE;
            cnt   <= '0;
            done  <= 1'b1;
          end
          default: begin state <= IDLE; cnt <= '0; end
        endcase
      end
    end
  end

endmodule
